// File: rtl/fpall_pkg.sv
// Shared FP types for the FP cluster: operand format tag and adder request payload.
package fpall_pkg;

    localparam int unsigned FP32_W            = 32;
    localparam int unsigned FPADD_ARB_MAX_REQ = 8;

    // FMT_FP32_FTZ flushes subnormal results to signed zero
    typedef enum logic [0:0] {
        FMT_FP32     = 1'b0,
        FMT_FP32_FTZ = 1'b1
    } fp_fmt_e;

    typedef struct packed {
        logic [FP32_W-1:0] x;
        logic [FP32_W-1:0] y;
        fp_fmt_e           fmt;
    } fpadd_req_t;

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder, round-to-nearest-even, optional flush-to-zero of subnormal results.
module fp32_add
    import fpall_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  fp_fmt_e     fmt,
    output logic [31:0] r
);

    logic [31:0] big, sml;
    logic [7:0]  ea, eb, d;
    logic [23:0] ma, mb;
    logic [26:0] mb_x, mb_al, mask, m27;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e10, sh, e_n;
    logic        rnd;
    logic [30:0] mag;
    logic        x_nan, y_nan, x_inf, y_inf;

    // Align, add/subtract magnitudes, normalise, round, then patch special values
    always_comb begin
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        ea   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        eb   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        ma   = {big[30:23] != 8'd0, big[22:0]};
        mb   = {sml[30:23] != 8'd0, sml[22:0]};
        d    = ea - eb;
        mb_x = {mb, 3'b000};
        mask = '0;
        if (d >= 8'd27) begin
            mb_al = {26'd0, |mb};
        end else begin
            mask     = (27'd1 << d) - 27'd1;
            mb_al    = mb_x >> d;
            mb_al[0] = mb_al[0] | (|(mb_x & mask));
        end
        if (big[31] ^ sml[31]) begin
            sum = {1'b0, ma, 3'b000} - {1'b0, mb_al};
        end else begin
            sum = {1'b0, ma, 3'b000} + {1'b0, mb_al};
        end
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        e10 = {2'b00, ea};
        sh  = '0;
        if (sum[27]) begin
            m27 = {sum[27:2], sum[1] | sum[0]};
            e_n = e10 + 10'd1;
        end else begin
            sh  = ((e10 - 10'd1) < {5'd0, lz}) ? (e10 - 10'd1) : {5'd0, lz};
            m27 = sum[26:0] << sh;
            e_n = m27[26] ? (e10 - sh) : 10'd0;
        end
        rnd = m27[2] & (m27[3] | m27[1] | m27[0]);
        mag = {e_n[7:0], m27[25:3]} + 31'(rnd);

        x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);

        if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
            r = 32'h7FC0_0000;
        end else if (x_inf) begin
            r = x;
        end else if (y_inf) begin
            r = y;
        end else if (sum == 28'd0) begin
            r = {big[31] & sml[31], 31'd0};
        end else if (e_n >= 10'd255) begin
            r = {big[31], 8'hFF, 23'd0};
        end else if ((fmt == FMT_FP32_FTZ) && (mag[30:23] == 8'd0)) begin
            r = {big[31], 31'd0};
        end else begin
            r = {big[31], mag};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    // Rotating priority search starting at ptr
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr) + k) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp32_add_arb.sv
// Round-robin scheduler sharing one fp32_add among NUM_REQ requesters,
// with a LAT-stage stallable pipeline and a tagged response channel.
// Optional build macro FPADD_ARB_STATS_EN adds saturating accept/stall counters.
module fp32_add_arb
    import fpall_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned LAT     = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_x,
    input  logic [NUM_REQ-1:0][31:0]  req_y,
    input  fp_fmt_e                   req_fmt [NUM_REQ],
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [31:0]               rsp_r
`ifdef FPADD_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]  stat_accept,
    output logic [15:0]               stat_stall
`endif
);

    logic [ID_W-1:0]    ptr, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               any, stall, accept;
    fpadd_req_t         s1_req;
    logic [ID_W-1:0]    s1_id;
    logic               s1_valid;
    logic [31:0]        add_r;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    fp32_add u_add (
        .x   (s1_req.x),
        .y   (s1_req.y),
        .fmt (s1_req.fmt),
        .r   (add_r)
    );

    assign stall     = rsp_valid & ~rsp_ready;
    assign accept    = any & ~stall & rst_n;
    assign req_ready = (rst_n && !stall) ? gnt : '0;

    // Priority pointer moves just past the accepted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Stage 1 captures the winner's operands, or a bubble when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_req   <= '0;
        end else if (!stall) begin
            s1_valid   <= accept;
            s1_id      <= gnt_idx;
            s1_req.x   <= req_x[gnt_idx];
            s1_req.y   <= req_y[gnt_idx];
            s1_req.fmt <= req_fmt[gnt_idx];
        end
    end

    if (LAT == 1) begin : g_lat1
        assign rsp_valid = s1_valid;
        assign rsp_id    = s1_id;
        assign rsp_r     = add_r;
    end else begin : g_latn
        logic [31:0]     res_q [LAT-1];
        logic [ID_W-1:0] id_q  [LAT-1];
        logic            vld_q [LAT-1];

        // Result stages 2..LAT shift together and freeze on stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < int'(LAT) - 1; j++) begin
                    res_q[j] <= '0;
                    id_q[j]  <= '0;
                    vld_q[j] <= 1'b0;
                end
            end else if (!stall) begin
                res_q[0] <= add_r;
                id_q[0]  <= s1_id;
                vld_q[0] <= s1_valid;
                for (int j = 1; j < int'(LAT) - 1; j++) begin
                    res_q[j] <= res_q[j-1];
                    id_q[j]  <= id_q[j-1];
                    vld_q[j] <= vld_q[j-1];
                end
            end
        end

        assign rsp_valid = vld_q[LAT-2];
        assign rsp_id    = id_q[LAT-2];
        assign rsp_r     = res_q[LAT-2];
    end

`ifdef FPADD_ARB_STATS_EN
    // Saturating per-requester accept and stall-cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept <= '0;
            stat_stall  <= '0;
        end else begin
            if (stall && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (accept && gnt[i] && (stat_accept[i] != 16'hFFFF)) begin
                    stat_accept[i] <= stat_accept[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
